// File: rtl/key_repeat_conditioner_pkg.sv
// Shared types and elaboration-time helpers for the key repeat conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HOLD,
    REPEAT
  } key_state_t;

  // Prescaler division ratio (TICK_DIV), derived from the system clock.
  function automatic int unsigned tick_div(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

  // Counter width that can hold the largest millisecond interval.
  function automatic int unsigned cnt_width(input int unsigned debounce_ms,
                                            input int unsigned hold_ms,
                                            input int unsigned repeat_ms);
    int unsigned m;
    m = debounce_ms;
    if (hold_ms > m)   m = hold_ms;
    if (repeat_ms > m) m = repeat_ms;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_repeat_conditioner_channel.sv
// One key: 2-flop synchroniser, debounce counter, press/hold/repeat FSM.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned CW          = 5,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned HOLD_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 1000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic tick_ms,
  input  logic key_in,
  output logic key_level,
  output logic key_pulse,
  output logic key_long
);

  logic          sync1, sync2;
  logic [CW-1:0] db_cnt;
  logic          accept, rise, fall;
  logic [CW-1:0] hold_cnt, hold_n, limit;
  logic          pulse_q, pulse_n;
  key_state_t    state, state_n;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign accept = (sync2 != key_level) && tick_ms && (db_cnt == CW'(DEBOUNCE_MS - 1));
  assign rise   = accept && !key_level;
  assign fall   = accept && key_level;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      db_cnt    <= '0;
      key_level <= 1'b0;
    end else if (sync2 == key_level) begin
      db_cnt <= '0;
    end else if (accept) begin
      db_cnt    <= '0;
      key_level <= ~key_level;
    end else if (tick_ms) begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

  assign limit = (state == REPEAT) ? CW'(REPEAT_MS - 1) : CW'(HOLD_MS - 1);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      pulse_q  <= pulse_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    pulse_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = WAIT_HOLD;
          hold_n  = '0;
          pulse_n = 1'b1;
        end
      end
      WAIT_HOLD, REPEAT: begin
        if (tick_ms) begin
          if (hold_cnt == limit) begin
            state_n = REPEAT;
            hold_n  = '0;
            pulse_n = 1'b1;
          end else begin
            hold_n = hold_cnt + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // A release accepted on an expiry tick suppresses that tick's pulse.
    if (fall) begin
      state_n = IDLE;
      hold_n  = '0;
      pulse_n = 1'b0;
    end
  end

  always_comb begin
    key_pulse = pulse_q;
    key_long  = (state == REPEAT);
  end

endmodule

// File: rtl/key_repeat_conditioner.sv
// Set-button conditioner: shared millisecond prescaler feeding N key channels.
module key_repeat_conditioner
  import key_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned N_KEYS      = 2,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned HOLD_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 1000
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_pulse,
  output logic [N_KEYS-1:0] key_long
);

  localparam int unsigned TICK_DIV = tick_div(CLK_HZ);
  localparam int unsigned PW       = $clog2(TICK_DIV + 1);
  localparam int unsigned CW       = cnt_width(DEBOUNCE_MS, HOLD_MS, REPEAT_MS);

  logic [PW-1:0] pre_cnt;
  logic          tick_ms;

  assign tick_ms = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)       pre_cnt <= '0;
    else if (tick_ms) pre_cnt <= '0;
    else              pre_cnt <= pre_cnt + PW'(1);
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_channel #(
      .CW          (CW),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .HOLD_MS     (HOLD_MS),
      .REPEAT_MS   (REPEAT_MS)
    ) u_channel (
      .clk       (clk),
      .clr_n     (clr_n),
      .tick_ms   (tick_ms),
      .key_in    (key_in[i]),
      .key_level (key_level[i]),
      .key_pulse (key_pulse[i]),
      .key_long  (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_repeat_conditioner.sv
// Bench for key_repeat_conditioner: pulse-timing scoreboard, vector table, corner sequences.
module tb_key_repeat_conditioner;

  logic       clk   = 1'b0;
  logic       clr_n = 1'b0;
  logic [1:0] key_in = 2'b00;
  logic [1:0] key_level, key_pulse, key_long;

  always #5 clk = ~clk;

  key_repeat_conditioner #(
    .CLK_HZ      (10_000),
    .N_KEYS      (2),
    .DEBOUNCE_MS (2),
    .HOLD_MS     (5),
    .REPEAT_MS   (3)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .key_in    (key_in),
    .key_level (key_level),
    .key_pulse (key_pulse),
    .key_long  (key_long)
  );

  // rel=0: absolute cycle window; rel=1: offset from that key's previous pulse
  typedef struct {
    int key;
    bit rel;
    int lo;
    int hi;
    bit lng;
  } exp_t;

  typedef struct {
    int key;
    int hold;
    int npulse;
    bit lng;
  } vec_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_pulse[2];
  bit   prev_pulse[2];
  int   pulse_cnt[2];
  bit   long_seen[2];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic monitor();
    int idx, lo, hi;
    for (int k = 0; k < 2; k++) begin
      if (key_long[k]) long_seen[k] = 1'b1;
      if (key_pulse[k]) begin
        chk($sformatf("pulse_gap_k%0d", k), int'(prev_pulse[k]), 0);
        idx = -1;
        foreach (sbq[i]) if (idx < 0 && sbq[i].key == k) idx = i;
        if (idx < 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse_k%0d: got pulse at cycle %0d want none", k, cyc);
        end else begin
          lo = sbq[idx].rel ? last_pulse[k] + sbq[idx].lo : sbq[idx].lo;
          hi = sbq[idx].rel ? last_pulse[k] + sbq[idx].hi : sbq[idx].hi;
          chk_rng($sformatf("pulse_time_k%0d", k), cyc, lo, hi);
          chk($sformatf("pulse_long_k%0d", k), int'(key_long[k]), int'(sbq[idx].lng));
          sbq.delete(idx);
        end
        last_pulse[k] = cyc;
        pulse_cnt[k]++;
      end
      prev_pulse[k] = key_pulse[k];
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push_first(input int k, input int c0);
    sbq.push_back('{key: k, rel: 1'b0, lo: c0 + 13, hi: c0 + 23, lng: 1'b0});
  endtask

  task automatic push_rep(input int k, input int d);
    sbq.push_back('{key: k, rel: 1'b1, lo: d, hi: d, lng: 1'b1});
  endtask

  task automatic wait_pulses(input string name, input int k, input int n, input int budget);
    int b;
    b = 0;
    while (pulse_cnt[k] < n && b < budget) begin
      step();
      b++;
    end
    if (pulse_cnt[k] < n) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pulses want %0d", name, pulse_cnt[k], n);
    end
  endtask

  task automatic check_drained(input string name);
    chk(name, sbq.size(), 0);
    sbq.delete();
  endtask

  vec_t vt[6];

  initial begin
    int k, pc0, pc1, c0, e, t;

    // Hold times that are multiples of 10 give a level-high time equal to the hold time.
    vt[0] = '{key: 0, hold: 8,   npulse: 0, lng: 1'b0};
    vt[1] = '{key: 0, hold: 40,  npulse: 1, lng: 1'b0};
    vt[2] = '{key: 1, hold: 30,  npulse: 1, lng: 1'b0};
    vt[3] = '{key: 0, hold: 100, npulse: 3, lng: 1'b1};
    vt[4] = '{key: 1, hold: 130, npulse: 4, lng: 1'b1};
    vt[5] = '{key: 0, hold: 140, npulse: 4, lng: 1'b1};

    for (int i = 0; i < 2; i++) begin
      last_pulse[i] = 0;
      prev_pulse[i] = 1'b0;
      pulse_cnt[i]  = 0;
      long_seen[i]  = 1'b0;
    end

    run(5);
    chk("rst_level", int'(key_level), 0);
    chk("rst_pulse", int'(key_pulse), 0);
    chk("rst_long",  int'(key_long),  0);
    clr_n = 1'b1;
    run(5);

    for (int v = 0; v < 6; v++) begin
      k   = vt[v].key;
      pc0 = pulse_cnt[k];
      long_seen[k] = 1'b0;
      key_in[k] = 1'b1;
      c0 = cyc;
      if (vt[v].npulse > 0) push_first(k, c0);
      if (vt[v].npulse > 1) push_rep(k, 50);
      for (int p = 2; p < vt[v].npulse; p++) push_rep(k, 30);
      run(vt[v].hold);
      key_in[k] = 1'b0;
      run(40);
      chk($sformatf("vec%0d_pulses", v), pulse_cnt[k] - pc0, vt[v].npulse);
      chk($sformatf("vec%0d_long_seen", v), int'(long_seen[k]), int'(vt[v].lng));
      chk($sformatf("vec%0d_level_end", v), int'(key_level[k]), 0);
      chk($sformatf("vec%0d_long_end", v), int'(key_long[k]), 0);
      check_drained($sformatf("vec%0d_missing", v));
    end

    // press and hold through five repeats, release right after the last one
    pc0 = pulse_cnt[0];
    key_in[0] = 1'b1;
    c0 = cyc;
    push_first(0, c0);
    push_rep(0, 50);
    repeat (4) push_rep(0, 30);
    wait_pulses("hold", 0, pc0 + 6, 300);
    key_in[0] = 1'b0;
    c0 = cyc;
    t = -1;
    for (int i = 0; i < 40 && t < 0; i++) begin
      step();
      if (!key_long[0]) t = cyc - c0;
    end
    chk_rng("hold_long_fall", t, 13, 23);
    run(20);
    check_drained("hold_missing");

    // release acceptance lands on the repeat-expiry tick
    pc0 = pulse_cnt[0];
    key_in[0] = 1'b1;
    c0 = cyc;
    push_first(0, c0);
    push_rep(0, 50);
    wait_pulses("race", 0, pc0 + 2, 200);
    e = cyc;
    run(12);
    key_in[0] = 1'b0;
    run(17);
    chk("race_pre_level", int'(key_level[0]), 1);
    chk("race_pre_long",  int'(key_long[0]),  1);
    step();
    chk("race_cycle", cyc - e, 30);
    chk("race_pulse", int'(key_pulse[0]), 0);
    chk("race_level", int'(key_level[0]), 0);
    chk("race_long",  int'(key_long[0]),  0);
    run(30);
    chk("race_no_extra", pulse_cnt[0] - pc0, 2);
    check_drained("race_missing");

    // simultaneous press; key 1 released early must not disturb key 0
    pc0 = pulse_cnt[0];
    pc1 = pulse_cnt[1];
    key_in = 2'b11;
    c0 = cyc;
    push_first(0, c0);
    push_first(1, c0);
    push_rep(0, 50);
    push_rep(0, 30);
    push_rep(0, 30);
    wait_pulses("indep_k1", 1, pc1 + 1, 40);
    chk("indep_k0_count", pulse_cnt[0] - pc0, 1);
    chk("indep_coincide", last_pulse[1] - last_pulse[0], 0);
    key_in[1] = 1'b0;
    wait_pulses("indep_k0", 0, pc0 + 4, 200);
    key_in[0] = 1'b0;
    run(40);
    chk("indep_k1_pulses", pulse_cnt[1] - pc1, 1);
    check_drained("indep_missing");

    // asynchronous reset on the cycle a repeat pulse is out
    pc0 = pulse_cnt[0];
    key_in[0] = 1'b1;
    c0 = cyc;
    push_first(0, c0);
    push_rep(0, 50);
    wait_pulses("reset_pre", 0, pc0 + 2, 200);
    chk("reset_inflight", int'(key_pulse[0]), 1);
    clr_n = 1'b0;
    #1;
    chk("reset_level", int'(key_level), 0);
    chk("reset_pulse", int'(key_pulse), 0);
    chk("reset_long",  int'(key_long),  0);
    sbq.delete();
    run(3);
    clr_n = 1'b1;
    pc0 = pulse_cnt[0];
    c0 = cyc;
    push_first(0, c0);
    wait_pulses("reset_post", 0, pc0 + 1, 40);
    key_in[0] = 1'b0;
    run(40);
    chk("reset_post_level", int'(key_level[0]), 0);
    check_drained("reset_missing");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
